spike_rate_decoder: RTL
=======================

# spike_rate_decoder

Receive side of the LIF network's spike interface: converts the single-bit spike trains from the neuron outputs back into multi-bit rate values, the inverse of the 5-bit input-current-to-spike path of the network. Over a programmable observation window it counts spikes per channel with saturation, then presents the latched counts and a winner-take-all index on a valid/ready output port. It sits between the spike outputs of `lif_neuron_network` and the top-level output pins or a downstream readout controller.

## Interface
- `NUM_CH`, 4: number of spike channels (final, 3, 2, 1 in network order)
- `CNT_W`, 8: per-channel count width; saturates at 2^CNT_W-1
- `WIN_W`, 8: width of the window-length input
- `clk` input 1: single clock; all state on rising edge
- `reset` input 1: asynchronous, active-high; clears all state
- `spike_in` input NUM_CH: one spike bit per channel, sampled each cycle in COUNT
- `window_len` input WIN_W: window length N in cycles, sampled with `start`; 0 treated as 1
- `start` input 1: begin a window (level-sampled, see Operation)
- `busy` output 1: high in COUNT
- `out_valid` output 1: latched result available
- `out_ready` input 1: downstream accepts result
- `count_out` output NUM_CH*CNT_W: channel k at bits [k*CNT_W +: CNT_W]
- `winner` output clog2(NUM_CH): index of highest count
- `overflow` output NUM_CH: per-channel sticky saturation flag for the latched window

## Operation
- FSM states: IDLE, COUNT, HOLD.
- IDLE: on edge with `start`=1, load window counter with max(window_len,1), clear working counters and working overflow flags, go COUNT.
- COUNT: each edge, every channel with `spike_in[k]`=1 increments its working counter; at 2^CNT_W-1 it holds and sets working overflow[k]. `start` ignored. Window counter decrements each edge.
- On the edge where the window counter goes 1→0 (the Nth sampling edge): output registers load sat(working count + spike_in) — the final-cycle spike is included — plus overflow flags and winner; `out_valid`←1; go HOLD.
- winner = channel with largest latched count; ties resolve to the lowest index; all zero → 0.
- HOLD: outputs stable while `out_valid`=1. Edge with `out_ready`=1: `out_valid`←0; if `start`=1 on the same edge, go directly to COUNT (new window loaded as from IDLE), else IDLE. `start` without `out_ready` is ignored.
- Output registers keep their last values after handshake until the next latch.
- Reset (any time, including mid-window or in HOLD): state IDLE, all counters, `count_out`, `winner`, `overflow` = 0, `out_valid`=0, `busy`=0; the partial window is discarded, no result is produced.

## Timing
- Reset values: `busy`=0, `out_valid`=0, `count_out`=0, `winner`=0, `overflow`=0.
- Start edge = edge 0. Spikes are sampled on edges 1..N. `busy` is high from after edge 0 to after edge N. `out_valid` rises after edge N (N cycles after start).
- Handshake completes on any edge with `out_valid` && `out_ready`; `out_ready` may be held high permanently (one-cycle valid pulse).
- Back-to-back: start held with ready gives a window of N sampling edges every N+1 cycles.
- All outputs are registered; no combinational input-to-output path.

## Structure
- Package `spike_decode_pkg`: state enum (IDLE, COUNT, HOLD), default widths, a saturating-max constant function.
- Sub-module `spike_sat_counter` (CNT_W, clear, inc, count, sat flag), instantiated NUM_CH times; winner compare is a linear priority scan in the top.

## Test plan
- Reset mid-COUNT after 3 of N=10 cycles with all spikes high → `busy`=0, `out_valid`=0, all outputs 0; next start with N=2 yields counts 2.
- N=5, channel 0 spikes every cycle, channel 2 on edges 1 and 5 only, others 0 → counts {5,0,2,0}, winner=0, overflow=0, `out_valid` rises 5 cycles after start.
- N=255, CNT_W=4 build, channel 1 high always → count 15, overflow[1]=1, others 0.
- Tie: channels 1 and 3 each 4 spikes, N=8 → winner=1.
- `out_ready` low 6 cycles in HOLD with `start` pulsing → outputs stable, no new window; ready+start on same edge → `busy`=1 next cycle.
- window_len=0 with channel 3 spiking → window of 1 cycle, count 1, winner=3.

Source files
------------

// File: rtl/spike_decode_pkg.sv
// Shared types and constants for the spike rate decoder.
package spike_decode_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_COUNT = 2'd1,
    ST_HOLD  = 2'd2
  } state_e;

  localparam int DEF_NUM_CH = 4;
  localparam int DEF_CNT_W  = 8;
  localparam int DEF_WIN_W  = 8;

  // Largest value representable in w bits; the point where counters stop.
  function automatic longint unsigned sat_max(input int unsigned w);
    return (64'd1 << w) - 64'd1;
  endfunction

endpackage

// File: rtl/spike_sat_counter.sv
// Per-channel saturating spike counter with a sticky lost-spike flag.
// count/sat present the value the counter takes at the coming edge, so the
// top can latch a window result that already includes the final spike.
module spike_sat_counter
  import spike_decode_pkg::*;
#(
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             inc,
  output logic [CNT_W-1:0] count,
  output logic             sat
);

  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(sat_max(CNT_W));

  logic [CNT_W-1:0] count_q, count_d;
  logic             sat_q, sat_d;

  // Next value: clear wins; an increment at full scale is dropped and flagged.
  always_comb begin
    count_d = count_q;
    sat_d   = sat_q;
    if (clear) begin
      count_d = '0;
      sat_d   = 1'b0;
    end else if (inc) begin
      if (count_q == MAX_CNT) sat_d = 1'b1;
      else count_d = count_q + CNT_W'(1);
    end
  end

  // Working count and flag registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
      sat_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      sat_q   <= sat_d;
    end
  end

  assign count = count_d;
  assign sat   = sat_d;

endmodule

// File: rtl/spike_rate_decoder.sv
// Counts spikes per channel over a programmable window and presents the
// latched counts, overflow flags and winner index on a valid/ready port.
//
//   state    | meaning
//   ST_IDLE  | waiting for start
//   ST_COUNT | sampling spikes, window counter running down
//   ST_HOLD  | result latched, out_valid high until accepted
module spike_rate_decoder
  import spike_decode_pkg::*;
#(
  parameter int NUM_CH = DEF_NUM_CH,
  parameter int CNT_W  = DEF_CNT_W,
  parameter int WIN_W  = DEF_WIN_W
) (
  input  logic                                        clk,
  input  logic                                        reset,
  input  logic [NUM_CH-1:0]                           spike_in,
  input  logic [WIN_W-1:0]                            window_len,
  input  logic                                        start,
  output logic                                        busy,
  output logic                                        out_valid,
  input  logic                                        out_ready,
  output logic [NUM_CH*CNT_W-1:0]                     count_out,
  output logic [$clog2(NUM_CH > 1 ? NUM_CH : 2)-1:0]  winner,
  output logic [NUM_CH-1:0]                           overflow
);

  localparam int WIDX_W = $clog2(NUM_CH > 1 ? NUM_CH : 2);

  state_e                    state_q, state_d;
  logic [WIN_W-1:0]          win_q, win_d;
  logic                      busy_q, busy_d;
  logic                      valid_q, valid_d;
  logic [NUM_CH*CNT_W-1:0]   count_q;
  logic [NUM_CH-1:0]         ovf_q;
  logic [WIDX_W-1:0]         winner_q, winner_d;

  logic                      clear_w;
  logic                      cnt_en;
  logic                      latch;
  logic [CNT_W-1:0]          nxt_cnt [NUM_CH];
  logic [NUM_CH*CNT_W-1:0]   nxt_flat;
  logic [NUM_CH-1:0]         nxt_sat;
  logic [CNT_W-1:0]          best;

  for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
    spike_sat_counter #(.CNT_W(CNT_W)) u_cnt (
      .clk   (clk),
      .reset (reset),
      .clear (clear_w),
      .inc   (cnt_en & spike_in[k]),
      .count (nxt_cnt[k]),
      .sat   (nxt_sat[k])
    );
    assign nxt_flat[k*CNT_W +: CNT_W] = nxt_cnt[k];
  end

  // Sequencing: window load, countdown, result hand-off.
  always_comb begin
    state_d = state_q;
    win_d   = win_q;
    busy_d  = busy_q;
    valid_d = valid_q;
    clear_w = 1'b0;
    cnt_en  = 1'b0;
    latch   = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_COUNT;
          win_d   = (window_len == '0) ? WIN_W'(1) : window_len;
          clear_w = 1'b1;
          busy_d  = 1'b1;
        end
      end
      ST_COUNT: begin
        cnt_en = 1'b1;
        win_d  = win_q - WIN_W'(1);
        if (win_q == WIN_W'(1)) begin
          latch   = 1'b1;
          state_d = ST_HOLD;
          busy_d  = 1'b0;
          valid_d = 1'b1;
        end
      end
      ST_HOLD: begin
        if (out_ready) begin
          valid_d = 1'b0;
          if (start) begin
            state_d = ST_COUNT;
            win_d   = (window_len == '0) ? WIN_W'(1) : window_len;
            clear_w = 1'b1;
            busy_d  = 1'b1;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
        valid_d = 1'b0;
      end
    endcase
  end

  // Winner: strict greater-than scan so ties keep the lowest index.
  always_comb begin
    winner_d = '0;
    best     = nxt_cnt[0];
    for (int k = 1; k < NUM_CH; k++) begin
      if (nxt_cnt[k] > best) begin
        best     = nxt_cnt[k];
        winner_d = WIDX_W'(k);
      end
    end
  end

  // Control state plus output registers loaded on the last sampling edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      win_q    <= '0;
      busy_q   <= 1'b0;
      valid_q  <= 1'b0;
      count_q  <= '0;
      ovf_q    <= '0;
      winner_q <= '0;
    end else begin
      state_q <= state_d;
      win_q   <= win_d;
      busy_q  <= busy_d;
      valid_q <= valid_d;
      if (latch) begin
        count_q  <= nxt_flat;
        ovf_q    <= nxt_sat;
        winner_q <= winner_d;
      end
    end
  end

  assign busy      = busy_q;
  assign out_valid = valid_q;
  assign count_out = count_q;
  assign winner    = winner_q;
  assign overflow  = ovf_q;

endmodule
